// File: rtl/lc3_rf_write_arbiter_if.sv
// lc3_rf_write_arbiter_if: requester/register-file bundle for the RF write-port arbiter
interface lc3_rf_write_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              core_req;
  logic [2:0]        core_dr;
  logic [DATA_W-1:0] core_data;
  logic              core_gnt;
  logic              sp_req;
  logic [DATA_W-1:0] sp_data;
  logic              sp_gnt;
  logic              dbg_req;
  logic [2:0]        dbg_dr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_gnt;
  logic              dbg_clr_start;
  logic              dbg_clr_busy;
  logic              dbg_clr_done;
  logic              rf_we;
  logic [2:0]        rf_wsel;
  logic [DATA_W-1:0] rf_wdata;
  modport master (
    output core_req, core_dr, core_data, sp_req, sp_data, dbg_req, dbg_dr, dbg_data, dbg_clr_start,
    input  core_gnt, sp_gnt, dbg_gnt, dbg_clr_busy, dbg_clr_done, rf_we, rf_wsel, rf_wdata
  );
  modport slave (
    input  core_req, core_dr, core_data, sp_req, sp_data, dbg_req, dbg_dr, dbg_data, dbg_clr_start,
    output core_gnt, sp_gnt, dbg_gnt, dbg_clr_busy, dbg_clr_done, rf_we, rf_wsel, rf_wdata
  );
endinterface

// File: rtl/lc3_rf_write_arbiter.sv
// lc3_rf_write_arbiter: shares the RF write port between core, sp and dbg plus a debug clear walk; LC3_RFARB_STARVE_GUARD_EN adds a starvation guard
module lc3_rf_write_arbiter #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
`ifdef LC3_RFARB_STARVE_GUARD_EN
  , parameter int              STARVE_LIMIT = 4
`endif
) (
  input logic clk,
  input logic rst,
  lc3_rf_write_arbiter_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic       rr;
  logic       idle, last, sp_c, dbg_c, clr_step, core_gnt, sp_gnt, dbg_gnt;
  assign idle = !rst && state == IDLE;
`ifdef LC3_RFARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] sp_wait, dbg_wait, clr_wait;
  logic          sp_force, dbg_force, clr_force, any_force;
  assign sp_force  = bus.sp_req && sp_wait >= CW'(STARVE_LIMIT);
  assign dbg_force = bus.dbg_req && dbg_wait >= CW'(STARVE_LIMIT);
  assign clr_force = clr_wait >= CW'(STARVE_LIMIT);
  assign any_force = idle ? (sp_force || dbg_force) : clr_force;
  assign core_gnt  = !rst && bus.core_req && !any_force;
  assign sp_c      = any_force ? sp_force : bus.sp_req && !bus.core_req;
  assign dbg_c     = any_force ? dbg_force : bus.dbg_req && !bus.core_req;
  // Saturating wait counters: cleared on grant or when not requesting
  always_ff @(posedge clk)
    if (rst) begin
      sp_wait  <= '0;
      dbg_wait <= '0;
      clr_wait <= '0;
    end else begin
      sp_wait  <= (!bus.sp_req || sp_gnt) ? '0 : sp_wait + CW'(sp_wait < CW'(STARVE_LIMIT));
      dbg_wait <= (!bus.dbg_req || dbg_gnt) ? '0 : dbg_wait + CW'(dbg_wait < CW'(STARVE_LIMIT));
      clr_wait <= (state != CLEAR || clr_step) ? '0 : clr_wait + CW'(clr_wait < CW'(STARVE_LIMIT));
    end
`else
  assign core_gnt = !rst && bus.core_req;
  assign sp_c     = bus.sp_req && !bus.core_req;
  assign dbg_c    = bus.dbg_req && !bus.core_req;
`endif
  assign sp_gnt       = idle && sp_c && (!dbg_c || !rr);
  assign dbg_gnt      = idle && dbg_c && (!sp_c || rr);
  assign clr_step     = !rst && state == CLEAR && !core_gnt;
  assign last         = clr_step && &cnt;
  assign bus.core_gnt = core_gnt;
  assign bus.sp_gnt   = sp_gnt;
  assign bus.dbg_gnt  = dbg_gnt;
  // Register the winning write, advance the clear walk and the sp/dbg round-robin pointer
  always_ff @(posedge clk)
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      rr               <= 1'b0;
      bus.rf_we        <= 1'b0;
      bus.rf_wsel      <= '0;
      bus.rf_wdata     <= '0;
      bus.dbg_clr_busy <= 1'b0;
      bus.dbg_clr_done <= 1'b0;
    end else begin
      bus.rf_we        <= core_gnt || sp_gnt || dbg_gnt || clr_step;
      bus.rf_wsel      <= core_gnt ? bus.core_dr : sp_gnt ? 3'd6 : dbg_gnt ? bus.dbg_dr : clr_step ? cnt : bus.rf_wsel;
      bus.rf_wdata     <= core_gnt ? bus.core_data : sp_gnt ? bus.sp_data : dbg_gnt ? bus.dbg_data : clr_step ? CLR_VALUE : bus.rf_wdata;
      rr               <= sp_gnt ? 1'b1 : dbg_gnt ? 1'b0 : rr;
      state            <= idle ? (bus.dbg_clr_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
      cnt              <= idle ? 3'd0 : cnt + 3'(clr_step);
      bus.dbg_clr_busy <= idle ? bus.dbg_clr_start : !last;
      bus.dbg_clr_done <= last;
    end
endmodule
